// File: rtl/peridot_txd_arbiter.sv
// peridot_txd_arbiter: packet round-robin of two byte sources onto one PHY, with channel headers and escaping
module peridot_txd_arbiter #(
    parameter logic [7:0] CHANNEL_MARK  = 8'h7C,
    parameter logic [7:0] ESCAPE_CODE   = 8'h7D,
    parameter bit         HEADER_ALWAYS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       in0_ready,
    input  logic       in0_valid,
    input  logic [7:0] in0_data,
    input  logic       in0_endofpacket,
    output logic       in1_ready,
    input  logic       in1_valid,
    input  logic [7:0] in1_data,
    input  logic       in1_endofpacket,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       grant,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, HDR_MARK, HDR_CH, DATA} state_t;
    state_t     state_q;
    logic       out_valid_q, pend_valid_q, eop_seen_q, grant_q, rr_last_q, last_ch_q, last_vld_q;
    logic [7:0] out_data_q, pend_data_q;
    logic       load, take, accept, sel_eop, is_esc, pick_d, need_hdr_d;
    logic [7:0] sel_data;
    assign load       = ~out_valid_q | out_ready;
    assign take       = (state_q == DATA) & load & ~pend_valid_q;
    assign in0_ready  = take & ~grant_q;
    assign in1_ready  = take & grant_q;
    assign sel_data   = grant_q ? in1_data : in0_data;
    assign sel_eop    = grant_q ? in1_endofpacket : in0_endofpacket;
    assign accept     = take & (grant_q ? in1_valid : in0_valid);
    assign is_esc     = (sel_data == CHANNEL_MARK) | (sel_data == ESCAPE_CODE);
    // a tie goes to the channel that did not win last time
    assign pick_d     = (in0_valid & in1_valid) ? ~rr_last_q : in1_valid;
    assign need_hdr_d = HEADER_ALWAYS | ~last_vld_q | (pick_d != last_ch_q);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE) | out_valid_q | pend_valid_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            eop_seen_q   <= 1'b0;
            grant_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            last_ch_q    <= 1'b0;
            last_vld_q   <= 1'b0;
        end else begin
            if (load) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (in0_valid | in1_valid) begin
                    grant_q   <= pick_d;
                    rr_last_q <= pick_d;
                    state_q   <= need_hdr_d ? HDR_MARK : DATA;
                end
                HDR_MARK: if (load) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= CHANNEL_MARK;
                    state_q     <= HDR_CH;
                end
                HDR_CH: if (load) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= {7'd0, grant_q};
                    last_ch_q   <= grant_q;
                    last_vld_q  <= 1'b1;
                    state_q     <= DATA;
                end
                DATA: if (load & pend_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= pend_data_q;
                    pend_valid_q <= 1'b0;
                    eop_seen_q   <= 1'b0;
                    if (eop_seen_q) state_q <= IDLE;
                end else if (accept) begin
                    out_valid_q <= 1'b1;
                    if (is_esc) begin
                        out_data_q   <= ESCAPE_CODE;
                        pend_data_q  <= sel_data ^ 8'h20;
                        pend_valid_q <= 1'b1;
                        eop_seen_q   <= sel_eop;
                    end else begin
                        out_data_q <= sel_data;
                        if (sel_eop) state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_peridot_txd_arbiter.sv
// tb_peridot_txd_arbiter: directed packets against hand-computed PHY byte streams
module tb_peridot_txd_arbiter;
    logic       clk = 1'b0, reset = 1'b1, sel = 1'b0, out_ready = 1'b1;
    logic       in0_valid = 1'b0, in0_eop = 1'b0, in1_valid = 1'b0, in1_eop = 1'b0;
    logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
    logic       r0_a, r1_a, ov_a, g_a, b_a, r0_b, r1_b, ov_b, g_b, b_b;
    logic [7:0] od_a, od_b;
    logic       in0_ready, in1_ready, out_valid, grant, busy;
    logic [7:0] out_data;
    logic [8:0] q0[$], q1[$];
    logic [7:0] got[$], exp_q[$];
    int         total = 0, bad = 0, r0n = 0, r1n = 0;

    always #5 clk = ~clk;

    peridot_txd_arbiter u_a (
        .clk(clk), .reset(reset),
        .in0_ready(r0_a), .in0_valid(in0_valid), .in0_data(in0_data), .in0_endofpacket(in0_eop),
        .in1_ready(r1_a), .in1_valid(in1_valid), .in1_data(in1_data), .in1_endofpacket(in1_eop),
        .out_ready(out_ready), .out_valid(ov_a), .out_data(od_a), .grant(g_a), .busy(b_a)
    );
    peridot_txd_arbiter #(.HEADER_ALWAYS(1'b1)) u_b (
        .clk(clk), .reset(reset),
        .in0_ready(r0_b), .in0_valid(in0_valid), .in0_data(in0_data), .in0_endofpacket(in0_eop),
        .in1_ready(r1_b), .in1_valid(in1_valid), .in1_data(in1_data), .in1_endofpacket(in1_eop),
        .out_ready(out_ready), .out_valid(ov_b), .out_data(od_b), .grant(g_b), .busy(b_b)
    );

    assign in0_ready = sel ? r0_b : r0_a;
    assign in1_ready = sel ? r1_b : r1_a;
    assign out_valid = sel ? ov_b : ov_a;
    assign out_data  = sel ? od_b : od_a;
    assign grant     = sel ? g_b : g_a;
    assign busy      = sel ? b_b : b_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in0_valid = q0.size() != 0;
        {in0_eop, in0_data} = q0.size() != 0 ? q0[0] : 9'h000;
        in1_valid = q1.size() != 0;
        {in1_eop, in1_data} = q1.size() != 0 ? q1[0] : 9'h000;
    endtask

    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        if (out_valid && out_ready) got.push_back(out_data);
        a0 = in0_ready && in0_valid;
        a1 = in1_ready && in1_valid;
        if (in0_ready) r0n++;
        if (in1_ready) r1n++;
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset(input logic s);
        sel = s;
        reset = 1'b1;
        out_ready = 1'b1;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) cycle();
        reset = 1'b0;
        got.delete();
        r0n = 0;
        r1n = 0;
    endtask

    task automatic run_done(input string tag);
        logic done = 1'b0;
        drive();
        for (int i = 0; i < 400 && !done; i++) begin
            cycle();
            done = q0.size() == 0 && q1.size() == 0 && !busy;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), i < got.size() ? {24'd0, got[i]} : 32'h1FF, {24'd0, exp_q[i]});
    endtask

    initial begin
        logic       found;
        logic       hv;
        logic [7:0] hd;
        do_reset(1'b0);
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        q0.push_back({1'b1, 8'h41});
        run_done("single");
        exp_q = '{8'h7C, 8'h00, 8'h41};
        cmp_stream("single");
        chk("single_rdy_cycles", r0n, 1);
        chk("single_busy", busy, 0);

        do_reset(1'b0);
        q0 = '{{1'b0, 8'h10}, {1'b1, 8'h11}};
        q1 = '{{1'b0, 8'h20}, {1'b1, 8'h21}};
        run_done("rr");
        exp_q = '{8'h7C, 8'h00, 8'h10, 8'h11, 8'h7C, 8'h01, 8'h20, 8'h21};
        cmp_stream("rr");
        chk("rr_grant", grant, 1);

        do_reset(1'b0);
        q0 = '{{1'b1, 8'h55}, {1'b1, 8'h66}};
        run_done("hdr0");
        exp_q = '{8'h7C, 8'h00, 8'h55, 8'h66};
        cmp_stream("hdr0");

        do_reset(1'b1);
        q0 = '{{1'b1, 8'h55}, {1'b1, 8'h66}};
        run_done("hdr1");
        exp_q = '{8'h7C, 8'h00, 8'h55, 8'h7C, 8'h00, 8'h66};
        cmp_stream("hdr1");

        do_reset(1'b0);
        q1 = '{{1'b0, 8'h7C}, {1'b1, 8'h7D}};
        run_done("esc");
        exp_q = '{8'h7C, 8'h01, 8'h7D, 8'h5C, 8'h7D, 8'h5D};
        cmp_stream("esc");
        chk("esc_rdy_cycles", r1n, 2);
        chk("esc_rdy0_cycles", r0n, 0);

        do_reset(1'b0);
        q0 = '{{1'b0, 8'h01}, {1'b0, 8'h02}, {1'b0, 8'h03}, {1'b0, 8'h04}, {1'b1, 8'h05}};
        drive();
        for (int i = 0; i < 50 && got.size() < 3; i++) cycle();
        chk("stall_reached", got.size(), 3);
        out_ready = 1'b0;
        hv = out_valid;
        hd = out_data;
        chk("stall_valid", hv, 1);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stall_hold_valid", out_valid, hv);
            chk("stall_hold_data", out_data, hd);
            chk("stall_in0_ready", in0_ready, 0);
        end
        out_ready = 1'b1;
        run_done("stall");
        exp_q = '{8'h7C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        cmp_stream("stall");

        do_reset(1'b0);
        q1 = '{{1'b0, 8'h7D}, {1'b1, 8'h41}};
        drive();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            found = out_valid && out_data == 8'h7D && got.size() == 2;
        end
        chk("rstpend_seen", found, 1);
        q1.delete();
        reset = 1'b1;
        drive();
        cycle();
        chk("rstpend_valid", out_valid, 0);
        chk("rstpend_busy", busy, 0);
        reset = 1'b0;
        got.delete();
        q1.push_back({1'b1, 8'h42});
        run_done("after_rst");
        exp_q = '{8'h7C, 8'h01, 8'h42};
        cmp_stream("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/peridot_txd_arbiter.md
# peridot_txd_arbiter

Packet-level round-robin arbiter that shares one UART sender PHY between two Avalon-ST byte sources. It sits between the host-bridge packet sources and the PHY's ready/valid/data input. When the granted channel changes, it inserts a two-byte channel header: marker, then channel number. Data bytes that collide with the marker or escape codes are escaped, so the receiver can demultiplex the byte stream.

## Interface
- CHANNEL_MARK, 8'h7C, header marker byte
- ESCAPE_CODE, 8'h7D, escape prefix byte
- HEADER_ALWAYS, 0, 1 = emit header before every packet; 0 = only when channel differs from last sent channel
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in0_ready  out  1  channel 0 byte accepted this cycle
- in0_valid  in  1  channel 0 byte available
- in0_data  in  8  channel 0 byte
- in0_endofpacket  in  1  channel 0 byte is last of packet
- in1_ready / in1_valid / in1_data / in1_endofpacket  same as channel 0, for channel 1
- out_ready  in  1  PHY can take a byte (PHY idle)
- out_valid  out  1  registered byte valid toward PHY
- out_data  out  8  registered byte toward PHY
- grant  out  1  currently/last granted channel
- busy  out  1  high whenever state != IDLE or out_valid or pending byte held

## Operation
- Clocking: one clock domain. Reset is synchronous and active-high.
- load = ~out_valid | out_ready. The output register (out_valid, out_data) updates only when load = 1. When load = 1 and nothing is issued, out_valid <= 0.
- State machine: IDLE, HDR_MARK, HDR_CH, DATA.
- IDLE, arbitration:
  - With no requests, stay in IDLE.
  - If exactly one inN_valid is high, grant N.
  - If both are high, grant the channel other than rr_last. rr_last resets to 1, so channel 0 wins the first tie.
  - On grant: grant <= N and rr_last <= N. Go to HDR_MARK if HEADER_ALWAYS = 1 or N != last_ch; otherwise go to DATA.
  - The IDLE cycle never loads the output register.
- HDR_MARK: on load, out_data <= CHANNEL_MARK, then go to HDR_CH.
- HDR_CH: on load, out_data <= {7'd0, grant}, last_ch <= grant, then go to DATA.
- DATA, normal byte:
  - inN_ready = (state == DATA) & (grant == N) & load & ~pend_valid. The ungranted channel's ready is always 0.
  - On an accepted byte d that is not CHANNEL_MARK or ESCAPE_CODE: out_data <= d.
- DATA, escaped byte:
  - If d equals CHANNEL_MARK or ESCAPE_CODE: out_data <= ESCAPE_CODE, pend_data <= d ^ 8'h20, pend_valid <= 1.
  - On the next load: out_data <= pend_data, pend_valid <= 0.
- Packet end:
  - If the accepted byte has endofpacket = 1, set eop_seen.
  - Return to IDLE on the load that issues the final byte: the byte itself, or its pending escaped half.
  - The grant is locked for the whole packet; no preemption.
- last_ch resets to "none" (an extra invalid flag), so the first packet after reset always gets a header.
- Channel-number bytes (0x00/0x01) are never escaped.

## Timing
- Reset values:
  - in0_ready = in1_ready = 0, out_valid = 0, out_data = 8'h00, grant = 0, busy = 0.
  - State IDLE, pend_valid = 0, last_ch invalid, rr_last = 1.
- Latency from inN_valid rising in IDLE (PHY idle, out_ready = 1):
  - With header: cycle 0 arbitrate; cycle 1 out_valid with MARK; cycle 2 channel byte; cycle 3 the first data byte is accepted (inN_ready = 1) and is presented on out_data from cycle 4.
  - Without header: cycle 0 arbitrate; cycle 1 the first data byte is accepted (inN_ready = 1) and is presented on out_data from cycle 2.
- One arbitration bubble cycle per packet.
- Throughput: at most one output byte per load. When out_ready = 0 with out_valid = 1, everything holds and in_ready = 0.
- inN_ready depends combinationally on out_ready. The source must not make valid depend on ready.
- Reset asserted mid-packet: all state clears next edge, out_valid drops, and any pending escape byte is discarded.

## Test plan
- After reset, ch0 sends one-byte packet 0x41 (eop) -> out sequence 0x7C, 0x00, 0x41; in0_ready high exactly one cycle; ends in IDLE, busy = 0.
- Both channels hold valid packets of 2 bytes each (ch0 0x10, 0x11; ch1 0x20, 0x21) -> 7C 00 10 11 7C 01 20 21. No interleaving inside a packet.
- Ch0 sends two consecutive packets 0x55 and 0x66 with HEADER_ALWAYS = 0 -> 7C 00 55 66; no second header. With HEADER_ALWAYS = 1 -> 7C 00 55 7C 00 66.
- Ch1 packet 0x7C, 0x7D (eop on 0x7D) -> 7C 01 7D 5C 7D 5D. in1_ready is low during each pending-byte cycle.
- PHY holds out_ready = 0 for 20 cycles mid-packet -> out_data/out_valid stable and in_ready = 0 throughout; the stream resumes with no loss or duplication.
- Assert reset while a pending escape byte is held -> out_valid = 0 and busy = 0 next cycle. The next packet starts with a header regardless of its channel.
